// File: rtl/sram_ctrl.sv
// Single-port asynchronous SRAM controller: turns one req/ready transaction at a time into a
// timed SRAM read or write cycle with registered pin controls and bus turnaround.
module sram_ctrl #(
  parameter int unsigned ADR_W   = 19,
  parameter int unsigned DAT_W   = 8,
  parameter int unsigned RD_WAIT = 2,
  parameter int unsigned WR_WAIT = 2,
  parameter int unsigned TURN    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req,
  input  logic             rw,
  input  logic [ADR_W-1:0] adr_in,
  input  logic [DAT_W-1:0] dat_in,
  output logic             ready,
  output logic [DAT_W-1:0] dat_out,
  output logic             dat_valid,
  output logic [ADR_W-1:0] sram_adr,
  inout  wire  [DAT_W-1:0] sram_dat,
  output logic             sram_we_n,
  output logic             sram_oe_n,
  output logic             sram_ce_n,
  output logic             sram_ub,
  output logic             sram_lb,
  output logic             bus_dir
);

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWrSetup,
    StWrPulse,
    StWrHold,
    StTurn
  } state_e;

  localparam logic [3:0] RdLoad   = 4'(RD_WAIT - 1);
  localparam logic [3:0] WrLoad   = 4'(WR_WAIT - 1);
  localparam logic [3:0] TurnLoad = 4'((TURN == 0) ? 0 : TURN - 1);
  localparam state_e     PostAcc  = (TURN == 0) ? StIdle : StTurn;

  state_e           state;
  logic [3:0]       cnt;
  logic [DAT_W-1:0] wr_dat;

  assign ready    = (state == StIdle);
  assign sram_ub  = sram_ce_n;
  assign sram_lb  = sram_ce_n;
  assign sram_dat = bus_dir ? wr_dat : {DAT_W{1'bz}};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= StIdle;
      cnt       <= 4'd0;
      wr_dat    <= '0;
      dat_out   <= '0;
      dat_valid <= 1'b0;
      sram_adr  <= '0;
      sram_we_n <= 1'b1;
      sram_oe_n <= 1'b1;
      sram_ce_n <= 1'b1;
      bus_dir   <= 1'b0;
    end else begin
      dat_valid <= 1'b0;
      unique case (state)
        StIdle: begin
          if (req) begin
            sram_adr  <= adr_in;
            wr_dat    <= dat_in;
            sram_ce_n <= 1'b0;
            if (rw) begin
              state   <= StWrSetup;
              bus_dir <= 1'b1;
              cnt     <= 4'd0;
            end else begin
              state     <= StRd;
              sram_oe_n <= 1'b0;
              cnt       <= RdLoad;
            end
          end
        end
        StRd: begin
          if (cnt == 4'd0) begin
            dat_out   <= sram_dat;
            dat_valid <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_ce_n <= 1'b1;
            state     <= PostAcc;
            cnt       <= TurnLoad;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        StWrSetup: begin
          state     <= StWrPulse;
          sram_we_n <= 1'b0;
          cnt       <= WrLoad;
        end
        StWrPulse: begin
          if (cnt == 4'd0) begin
            state     <= StWrHold;
            sram_we_n <= 1'b1;
            cnt       <= 4'd0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        StWrHold: begin
          // Release the bus together with chip enable so the next read never overlaps a drive.
          bus_dir   <= 1'b0;
          sram_ce_n <= 1'b1;
          state     <= PostAcc;
          cnt       <= TurnLoad;
        end
        StTurn: begin
          if (cnt == 4'd0) state <= StIdle;
          else             cnt   <= cnt - 4'd1;
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl: default instance plus a RD_WAIT=1/TURN=0 instance, each with
// a small asynchronous SRAM model on its data bus.
module tb_sram_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic        rw = 1'b0;
  logic [18:0] adr_in = '0;
  logic [7:0]  dat_in = '0;

  logic        ready0, dat_valid0, we_n0, oe_n0, ce_n0, ub0, lb0, dir0;
  logic [7:0]  dat_out0;
  logic [18:0] sram_adr0;
  wire  [7:0]  sram_dat0;

  logic        ready1, dat_valid1, we_n1, oe_n1, ce_n1, ub1, lb1, dir1;
  logic [7:0]  dat_out1;
  logic [18:0] sram_adr1;
  wire  [7:0]  sram_dat1;

  int n_cmp = 0;
  int n_err = 0;
  int we_falls = 0;
  int overlap = 0;
  logic [18:0] wr_adr = '0;
  logic [7:0]  wr_dat = '0;

  always #5 clk = ~clk;

  sram_ctrl u0 (
    .clk(clk), .reset(reset), .req(req0), .rw(rw), .adr_in(adr_in), .dat_in(dat_in),
    .ready(ready0), .dat_out(dat_out0), .dat_valid(dat_valid0), .sram_adr(sram_adr0),
    .sram_dat(sram_dat0), .sram_we_n(we_n0), .sram_oe_n(oe_n0), .sram_ce_n(ce_n0),
    .sram_ub(ub0), .sram_lb(lb0), .bus_dir(dir0)
  );

  sram_ctrl #(.RD_WAIT(1), .TURN(0)) u1 (
    .clk(clk), .reset(reset), .req(req1), .rw(rw), .adr_in(adr_in), .dat_in(dat_in),
    .ready(ready1), .dat_out(dat_out1), .dat_valid(dat_valid1), .sram_adr(sram_adr1),
    .sram_dat(sram_dat1), .sram_we_n(we_n1), .sram_oe_n(oe_n1), .sram_ce_n(ce_n1),
    .sram_ub(ub1), .sram_lb(lb1), .bus_dir(dir1)
  );

  // SRAM contents: 0xF0 at the top address, low address byte + 0x40 elsewhere.
  function automatic logic [7:0] model(input logic [18:0] a);
    return (a == 19'h7FFFF) ? 8'hF0 : a[7:0] + 8'h40;
  endfunction

  assign sram_dat0 = (!oe_n0 && !ce_n0) ? model(sram_adr0) : 8'hzz;
  assign sram_dat1 = (!oe_n1 && !ce_n1) ? model(sram_adr1) : 8'hzz;

  always @(negedge we_n0) we_falls++;
  always @(posedge we_n0) if (reset) begin wr_adr = sram_adr0; wr_dat = sram_dat0; end
  always @(negedge clk) if (!oe_n0 && dir0) overlap++;

  function automatic logic [4:0] ctl0();
    return {ready0, ce_n0, oe_n0, we_n0, dir0};
  endfunction

  function automatic logic [4:0] ctl1();
    return {ready1, ce_n1, oe_n1, we_n1, dir1};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  // Control bundle order: {ready, ce_n, oe_n, we_n, bus_dir}
  localparam logic [4:0] CIdle  = 5'b11110;
  localparam logic [4:0] CTurn  = 5'b01110;
  localparam logic [4:0] CRd    = 5'b00010;
  localparam logic [4:0] CWrDrv = 5'b00111;
  localparam logic [4:0] CWrPul = 5'b00101;

  initial begin
    // Reset state
    cyc(); cyc();
    chk("rst_ctl", 32'(ctl0()), 32'(CIdle));
    chk("rst_ublb", 32'({ub0, lb0}), 32'h3);
    chk("rst_adr", 32'(sram_adr0), 32'h0);
    chk("rst_dout", 32'({dat_out0, dat_valid0}), 32'h0);
    reset = 1'b1;
    cyc();

    // Write 0xAA to 0x00055
    adr_in = 19'h00055; dat_in = 8'hAA; rw = 1'b1; req0 = 1'b1;
    cyc(); req0 = 1'b0;
    chk("wr_setup", 32'(ctl0()), 32'(CWrDrv));
    chk("wr_setup_adr", 32'(sram_adr0), 32'h55);
    chk("wr_setup_dat", 32'(sram_dat0), 32'hAA);
    cyc(); chk("wr_pulse1", 32'(ctl0()), 32'(CWrPul));
    chk("wr_pulse1_dat", 32'(sram_dat0), 32'hAA);
    cyc(); chk("wr_pulse2", 32'(ctl0()), 32'(CWrPul));
    cyc(); chk("wr_hold", 32'(ctl0()), 32'(CWrDrv));
    chk("wr_hold_dat", 32'({sram_adr0, sram_dat0}), 32'({19'h55, 8'hAA}));
    cyc(); chk("wr_turn", 32'(ctl0()), 32'(CTurn));
    cyc(); chk("wr_ready", 32'(ctl0()), 32'(CIdle));
    chk("wr_captured", 32'({wr_adr, wr_dat}), 32'({19'h55, 8'hAA}));

    // Read 0x7FFFF -> 0xF0
    adr_in = 19'h7FFFF; rw = 1'b0; req0 = 1'b1;
    cyc(); req0 = 1'b0;
    chk("rd_1", 32'(ctl0()), 32'(CRd));
    chk("rd_1_adr", 32'(sram_adr0), 32'h7FFFF);
    cyc(); chk("rd_2", 32'(ctl0()), 32'(CRd));
    chk("rd_2_valid", 32'(dat_valid0), 32'h0);
    cyc(); chk("rd_turn", 32'(ctl0()), 32'(CTurn));
    chk("rd_data", 32'({dat_valid0, dat_out0}), 32'h1F0);
    cyc(); chk("rd_ready", 32'(ctl0()), 32'(CIdle));
    chk("rd_hold", 32'({dat_valid0, dat_out0}), 32'h0F0);

    // Busy: request during WR_PULSE is ignored
    we_falls = 0;
    adr_in = 19'h00100; dat_in = 8'h3C; rw = 1'b1; req0 = 1'b1;
    cyc(); req0 = 1'b0;
    cyc(); req0 = 1'b1; rw = 1'b0; adr_in = 19'h00001;
    cyc(); req0 = 1'b0; adr_in = 19'h02222;
    chk("busy_adr", 32'(sram_adr0), 32'h100);
    chk("busy_pulse", 32'(ctl0()), 32'(CWrPul));
    cyc(); chk("busy_hold", 32'({sram_adr0, sram_dat0}), 32'({19'h100, 8'h3C}));
    cyc(); cyc(); chk("busy_ready", 32'(ctl0()), 32'(CIdle));
    cyc(); chk("busy_no_extra", 32'(ctl0()), 32'(CIdle));
    chk("busy_adr_kept", 32'(sram_adr0), 32'h100);
    chk("busy_we_pulses", 32'(we_falls), 32'd1);

    // Turnaround: req held high, write 0x12 @0x10 then read @0x20
    adr_in = 19'h00010; dat_in = 8'h12; rw = 1'b1; req0 = 1'b1;
    cyc(); rw = 1'b0; adr_in = 19'h00020;
    cyc(); cyc(); cyc();
    cyc(); chk("ta_gap", 32'(ctl0()), 32'(CTurn));
    cyc(); chk("ta_idle", 32'(ctl0()), 32'(CIdle));
    chk("ta_wr", 32'({wr_adr, wr_dat}), 32'({19'h10, 8'h12}));
    cyc(); req0 = 1'b0;
    chk("ta_rd", 32'(ctl0()), 32'(CRd));
    chk("ta_rd_adr", 32'(sram_adr0), 32'h20);
    cyc(); cyc();
    chk("ta_rd_data", 32'({dat_valid0, dat_out0}), 32'h160);
    cyc();
    chk("no_overlap", 32'(overlap), 32'd0);

    // Reset during WR_PULSE aborts immediately
    adr_in = 19'h00077; dat_in = 8'h55; rw = 1'b1; req0 = 1'b1;
    cyc(); req0 = 1'b0;
    cyc(); chk("pre_rst_we", 32'(we_n0), 32'h0);
    reset = 1'b0; #1;
    chk("arst_ctl", 32'(ctl0()), 32'(CIdle));
    chk("arst_ublb", 32'({ub0, lb0}), 32'h3);
    chk("arst_adr", 32'({sram_adr0, dat_out0}), 32'h0);
    cyc(); reset = 1'b1;
    cyc(); chk("arst_after", 32'({ctl0(), dat_valid0}), 32'({CIdle, 1'b0}));

    // RD_WAIT=1, TURN=0 instance: back-to-back reads every 2 cycles
    adr_in = 19'h7FFFF; rw = 1'b0; req1 = 1'b1;
    cyc(); adr_in = 19'h00020;
    chk("p_rd1", 32'(ctl1()), 32'(CRd));
    cyc(); chk("p_rdy1", 32'(ctl1()), 32'(CIdle));
    chk("p_dat1", 32'({dat_valid1, dat_out1}), 32'h1F0);
    cyc(); chk("p_rd2", 32'(ctl1()), 32'(CRd));
    chk("p_rd2_adr", 32'({sram_adr1, dat_valid1}), 32'({19'h20, 1'b0}));
    cyc(); req1 = 1'b0;
    chk("p_rdy2", 32'(ctl1()), 32'(CIdle));
    chk("p_dat2", 32'({dat_valid1, dat_out1}), 32'h160);
    cyc(); chk("p_idle", 32'({ctl1(), dat_valid1}), 32'({CIdle, 1'b0}));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
